mem_stage: RTL and testbench

Memory stage of the 16-bit core. It consumes the ALU/Mem pipeline buffer outputs and performs the data-memory access: load, store, push, pop, call and ret. It owns the stack pointer and drives a req/ready data-memory port. It produces the registered result for the Mem/WB buffer and stalls upstream buffers while a memory transaction is in flight.

---
 rtl/mem_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the 16-bit core: runs LOAD/STORE/PUSH/POP/CALL/RET over a
// req/ready data-memory port, owns the stack pointer and stalls upstream while busy.
module mem_stage #(
  parameter int unsigned       ADDR_W  = 20,
  parameter logic [ADDR_W-1:0] SP_INIT = 20'hFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_WB,
  input  logic              i_Mem,
  input  logic [2:0]        i_mem_op,
  input  logic [31:0]       i_pc,
  input  logic [2:0]        i_Rdst,
  input  logic [15:0]       i_alu,
  input  logic [15:0]       i_read_data1,
  output logic              o_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic              o_valid,
  output logic              o_WB,
  output logic [2:0]        o_Rdst,
  output logic [15:0]       o_result,
  output logic              o_pc_load,
  output logic [31:0]       o_pc_target,
  output logic [ADDR_W-1:0] o_sp
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned RD_W   = 3;

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2} state_e;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                wb_q, wb_d;
  logic [RD_W-1:0]     rdst_q, rdst_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic                valid_q, valid_d;
  logic                o_wb_q, o_wb_d;
  logic [RD_W-1:0]     o_rdst_q, o_rdst_d;
  logic [DATA_W-1:0]   o_result_q, o_result_d;
  logic                pc_load_q, pc_load_d;
  logic [PC_W-1:0]     pc_target_q, pc_target_d;

  op_e  in_op;
  logic retire;

  // Effective op: non-memory instructions and the reserved code behave as NONE
  always_comb begin
    in_op = op_e'(i_mem_op);
    if (!i_Mem || in_op == OP_RSVD) in_op = OP_NONE;
  end

  // State register and all captured/result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      wb_q        <= 1'b0;
      rdst_q      <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      sp_q        <= SP_INIT;
      valid_q     <= 1'b0;
      o_wb_q      <= 1'b0;
      o_rdst_q    <= '0;
      o_result_q  <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wb_q        <= wb_d;
      rdst_q      <= rdst_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      sp_q        <= sp_d;
      valid_q     <= valid_d;
      o_wb_q      <= o_wb_d;
      o_rdst_q    <= o_rdst_d;
      o_result_q  <= o_result_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
    end
  end

  // Next state, capture, retirement and SP commit
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wb_d        = wb_q;
    rdst_d      = rdst_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    sp_d        = sp_q;
    valid_d     = 1'b0;
    o_wb_d      = 1'b0;
    pc_load_d   = 1'b0;
    o_rdst_d    = o_rdst_q;
    o_result_d  = o_result_q;
    pc_target_d = pc_target_q;
    retire      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (in_op == OP_NONE) begin
            valid_d     = 1'b1;
            o_wb_d      = i_WB;
            o_rdst_d    = i_Rdst;
            o_result_d  = i_alu;
            pc_target_d = '0;
          end else begin
            state_d = S_ACC1;
            op_d    = in_op;
            wb_d    = i_WB;
            rdst_d  = i_Rdst;
            pc_d    = i_pc;
            alu_d   = i_alu;
            wdata_d = i_read_data1;
          end
        end
      end
      S_ACC1: begin
        if (mem_ready) begin
          if (op_q == OP_CALL || op_q == OP_RET) begin
            state_d = S_ACC2;
            lo_d    = mem_rdata;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_ACC2: begin
        if (mem_ready) retire = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      state_d    = S_IDLE;
      valid_d    = 1'b1;
      o_rdst_d   = rdst_q;
      o_wb_d     = wb_q && !(op_q == OP_STORE || op_q == OP_CALL || op_q == OP_RET);
      o_result_d = (op_q == OP_LOAD || op_q == OP_POP) ? mem_rdata : alu_q;
      pc_load_d  = (op_q == OP_RET);
      pc_target_d = (op_q == OP_RET) ? {mem_rdata, lo_q} : '0;
      case (op_q)
        OP_PUSH: sp_d = sp_q - ADDR_W'(1);
        OP_POP:  sp_d = sp_q + ADDR_W'(1);
        OP_CALL: sp_d = sp_q - ADDR_W'(2);
        OP_RET:  sp_d = sp_q + ADDR_W'(2);
        default: sp_d = sp_q;
      endcase
    end
  end

  // Memory port decode from the captured op and current access phase
  always_comb begin
    mem_req   = (state_q != S_IDLE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      case (op_q)
        OP_LOAD: mem_addr = ADDR_W'(alu_q);
        OP_STORE: begin
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(alu_q);
          mem_wdata = wdata_q;
        end
        OP_PUSH: begin
          mem_we    = 1'b1;
          mem_addr  = sp_q;
          mem_wdata = wdata_q;
        end
        OP_POP: mem_addr = sp_q + ADDR_W'(1);
        OP_CALL: begin
          mem_we    = 1'b1;
          mem_addr  = (state_q == S_ACC1) ? sp_q : sp_q - ADDR_W'(1);
          mem_wdata = (state_q == S_ACC1) ? pc_q[31:16] : pc_q[15:0];
        end
        OP_RET: mem_addr = (state_q == S_ACC1) ? sp_q + ADDR_W'(1) : sp_q + ADDR_W'(2);
        default: mem_addr = '0;
      endcase
    end
  end

  assign o_stall     = (state_q != S_IDLE);
  assign o_valid     = valid_q;
  assign o_WB        = o_wb_q;
  assign o_Rdst      = o_rdst_q;
  assign o_result    = o_result_q;
  assign o_pc_load   = pc_load_q;
  assign o_pc_target = pc_target_q;
  assign o_sp        = sp_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected memory accesses and retirements are
// queued at issue and matched against a latency-configurable memory responder.
`timescale 1ns/1ps
module tb_mem_stage;
  localparam logic [19:0] SP_INIT  = 20'hFFFFF;
  localparam logic [2:0]  OP_NONE  = 3'd0;
  localparam logic [2:0]  OP_LOAD  = 3'd1;
  localparam logic [2:0]  OP_STORE = 3'd2;
  localparam logic [2:0]  OP_PUSH  = 3'd3;
  localparam logic [2:0]  OP_POP   = 3'd4;
  localparam logic [2:0]  OP_CALL  = 3'd5;
  localparam logic [2:0]  OP_RET   = 3'd6;
  localparam logic [2:0]  OP_RSVD  = 3'd7;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [15:0] data;
  } acc_t;

  typedef struct packed {
    logic        wb;
    logic [2:0]  rdst;
    logic [15:0] result;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [19:0] sp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_WB, i_Mem;
  logic [2:0]  i_mem_op, i_Rdst;
  logic [31:0] i_pc;
  logic [15:0] i_alu, i_read_data1;
  logic        o_stall, mem_req, mem_we, mem_ready;
  logic [19:0] mem_addr, o_sp;
  logic [15:0] mem_wdata, mem_rdata, o_result;
  logic        o_valid, o_WB, o_pc_load;
  logic [2:0]  o_Rdst;
  logic [31:0] o_pc_target;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [15:0] mem_model [logic [19:0]];
  logic [15:0] ref_mem   [logic [19:0]];
  logic [19:0] sp_m;
  int          n_checks    = 0;
  int          n_pass      = 0;
  int          ready_delay = 0;
  int          wait_cnt    = 0;
  logic        spurious    = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_WB(i_WB), .i_Mem(i_Mem),
    .i_mem_op(i_mem_op), .i_pc(i_pc), .i_Rdst(i_Rdst), .i_alu(i_alu),
    .i_read_data1(i_read_data1), .o_stall(o_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .o_valid(o_valid),
    .o_WB(o_WB), .o_Rdst(o_Rdst), .o_result(o_result), .o_pc_load(o_pc_load),
    .o_pc_target(o_pc_target), .o_sp(o_sp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic push_acc(input logic we, input logic [19:0] a, input logic [15:0] d);
    acc_t e;
    e.we = we; e.addr = a; e.data = d;
    acc_q.push_back(e);
    if (we) ref_mem[a] = d;
  endtask

  // Memory responder: ready after ready_delay waiting cycles per word
  always @(negedge clk) begin
    acc_t e;
    if (mem_ready || !mem_req) wait_cnt = 0;
    mem_ready = 1'b0;
    if (mem_req === 1'b1 && !rst) begin
      if (wait_cnt >= ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        if (acc_q.size() == 0) begin
          check("acc_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
        end else begin
          e = acc_q.pop_front();
          check("acc_we", 64'(mem_we), 64'(e.we));
          check("acc_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) check("acc_wdata", 64'(mem_wdata), 64'(e.data));
        end
      end else begin
        wait_cnt++;
      end
    end else if (spurious) begin
      mem_ready = 1'b1;
      mem_rdata = 16'hDEAD;
    end
  end

  // Retirement checker
  always @(negedge clk) begin
    res_t r;
    if (o_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        check("valid_unexpected", 64'(o_result), 64'hFFFF_FFFF);
      end else begin
        r = res_q.pop_front();
        check("o_WB", 64'(o_WB), 64'(r.wb));
        check("o_Rdst", 64'(o_Rdst), 64'(r.rdst));
        check("o_result", 64'(o_result), 64'(r.result));
        check("o_pc_load", 64'(o_pc_load), 64'(r.pc_load));
        check("o_pc_target", 64'(o_pc_target), 64'(r.pc_target));
        check("o_sp", 64'(o_sp), 64'(r.sp));
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic mem, input logic wb, input logic [2:0] rdst,
                       input logic [15:0] alu, input logic [15:0] rd1, input logic [31:0] pc);
    i_valid = 1'b1; i_mem_op = op; i_Mem = mem; i_WB = wb; i_Rdst = rdst;
    i_alu = alu; i_read_data1 = rd1; i_pc = pc;
  endtask

  // Issue one instruction in IDLE, model it, and measure the stall window
  task automatic send(input logic [2:0] op, input logic mem, input logic wb, input logic [2:0] rdst,
                      input logic [15:0] alu, input logic [15:0] rd1, input logic [31:0] pc,
                      input int dly);
    res_t        r;
    int          words;
    int          cnt;
    logic [2:0]  eop;
    logic [19:0] a;
    eop = (!mem || op == OP_RSVD) ? OP_NONE : op;
    r = '0; r.wb = wb; r.rdst = rdst; r.result = alu; words = 1;
    case (eop)
      OP_LOAD: begin
        a = 20'(alu); push_acc(1'b0, a, 16'h0); r.result = ref_rd(a);
      end
      OP_STORE: begin push_acc(1'b1, 20'(alu), rd1); r.wb = 1'b0; end
      OP_PUSH: begin push_acc(1'b1, sp_m, rd1); sp_m = sp_m - 20'd1; end
      OP_POP: begin
        a = sp_m + 20'd1; push_acc(1'b0, a, 16'h0); r.result = ref_rd(a); sp_m = a;
      end
      OP_CALL: begin
        push_acc(1'b1, sp_m, pc[31:16]); push_acc(1'b1, sp_m - 20'd1, pc[15:0]);
        sp_m = sp_m - 20'd2; r.wb = 1'b0; words = 2;
      end
      OP_RET: begin
        push_acc(1'b0, sp_m + 20'd1, 16'h0); push_acc(1'b0, sp_m + 20'd2, 16'h0);
        r.pc_load = 1'b1; r.pc_target = {ref_rd(sp_m + 20'd2), ref_rd(sp_m + 20'd1)};
        sp_m = sp_m + 20'd2; r.wb = 1'b0; words = 2;
      end
      default: words = 0;
    endcase
    r.sp = sp_m;
    res_q.push_back(r);
    ready_delay = dly;
    drive(op, mem, wb, rdst, alu, rd1, pc);
    @(posedge clk); #1;
    cnt = 0;
    while (o_stall && cnt < 100) begin
      i_valid = 1'($urandom); i_mem_op = 3'($urandom); i_alu = 16'($urandom);
      i_read_data1 = 16'($urandom); i_pc = $urandom; i_Rdst = 3'($urandom);
      cnt++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("stall_cycles", 64'(cnt), 64'(words * (dly + 1)));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; i_valid = 1'b0; i_WB = 1'b0; i_Mem = 1'b0; i_mem_op = '0;
    i_Rdst = '0; i_pc = '0; i_alu = '0; i_read_data1 = '0;
    mem_ready = 1'b0; mem_rdata = '0; sp_m = SP_INIT;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_stall", 64'(o_stall), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_o_result", 64'(o_result), 64'd0);
    check("rst_o_pc", 64'({o_pc_load, o_pc_target, o_WB, o_Rdst}), 64'd0);
    check("rst_o_sp", 64'(o_sp), 64'(SP_INIT));

    send(OP_NONE, 1'b1, 1'b1, 3'd5, 16'h1234, 16'h0, 32'h0, 0);
    send(OP_STORE, 1'b1, 1'b1, 3'd2, 16'h0040, 16'hBEEF, 32'h0, 2);
    send(OP_LOAD, 1'b1, 1'b1, 3'd3, 16'h0040, 16'h0, 32'h0, 2);
    send(OP_PUSH, 1'b1, 1'b1, 3'd1, 16'h0077, 16'hAAAA, 32'h0, 0);
    send(OP_POP, 1'b1, 1'b1, 3'd4, 16'h0088, 16'h0, 32'h0, 1);
    send(OP_CALL, 1'b1, 1'b1, 3'd7, 16'h0099, 16'h0, 32'h0001_0203, 1);
    send(OP_RET, 1'b1, 1'b1, 3'd6, 16'h00AA, 16'h0, 32'h0, 0);
    send(OP_LOAD, 1'b0, 1'b1, 3'd2, 16'h4321, 16'h0, 32'h0, 0);
    send(OP_RSVD, 1'b1, 1'b0, 3'd1, 16'h5555, 16'h0, 32'h0, 0);

    // mem_ready while idle must not disturb anything
    spurious = 1'b1;
    repeat (3) @(posedge clk);
    #1 spurious = 1'b0;
    check("spurious_stall", 64'(o_stall), 64'd0);
    check("spurious_sp", 64'(o_sp), 64'(sp_m));

    // POP from the top of the stack wraps to address 0
    send(OP_STORE, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h5A5A, 32'h0, 0);
    send(OP_POP, 1'b1, 1'b1, 3'd2, 16'h0000, 16'h0, 32'h0, 0);
    check("wrap_sp", 64'(o_sp), 64'h0);

    // Reset during the second word of a CALL abandons it
    ready_delay = 3;
    push_acc(1'b1, sp_m, 16'h0001);
    drive(OP_CALL, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 32'h0001_0203);
    @(posedge clk); #1;
    i_valid = 1'b0;
    cnt = 0;
    while (!(mem_req && mem_addr == sp_m - 20'd1) && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("acc2_reached", 64'(cnt < 100), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_o_valid", 64'(o_valid), 64'd0);
    check("abort_o_stall", 64'(o_stall), 64'd0);
    check("abort_o_sp", 64'(o_sp), 64'(SP_INIT));
    rst = 1'b0;
    sp_m = SP_INIT;

    for (int k = 0; k < 12; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 4));
      send(op, 1'b1, 1'b1, 3'($urandom), {12'h0, 4'($urandom)}, 16'($urandom),
           $urandom, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("acc_q_empty", 64'(acc_q.size()), 64'd0);
    check("res_q_empty", 64'(res_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
